// File: rtl/spi_mem_pkg.sv
// Shared opcode/state types for the burst-capable SPI memory slave.
// Optional build macro: SPI_SLAVE_PARITY_EN (adds WPAR/RPAR states).
package spi_mem_pkg;

   // Wire opcode: bit 0 selects write, bit 1 selects burst
   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_BRD = 2'b10,
      OP_BWR = 2'b11
   } op_t;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_CMD     = 4'd1,
      S_ADDR    = 4'd2,
      S_WDATA   = 4'd3,
`ifdef SPI_SLAVE_PARITY_EN
      S_WPAR    = 4'd4,
      S_RPAR    = 4'd8,
`endif
      S_WCOMMIT = 4'd5,
      S_RD_PREP = 4'd6,
      S_RDATA   = 4'd7,
      S_RDONE   = 4'd9
   } state_t;

   // States in which a chip-select release cancels the transfer
   function automatic logic abortable(input state_t s);
      case (s)
         S_CMD, S_ADDR, S_WDATA, S_RDATA: return 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
         S_WPAR, S_RPAR:                  return 1'b1;
`endif
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic logic is_write(input op_t op);
      return (op == OP_WR) || (op == OP_BWR);
   endfunction

   function automatic logic is_burst(input op_t op);
      return (op == OP_BRD) || (op == OP_BWR);
   endfunction

endpackage

// File: rtl/spi_slave_mem_array.sv
// DEPTH x DATA_W storage: synchronous write, registered read, range check.
module spi_slave_mem_array #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              in_range_c
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;

   assign in_range_c = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
   assign idx        = IDX_W'(addr);

   // Write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

   // Registered read port; out-of-range reads return zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= in_range_c ? mem[idx] : '0;
      end
   end

endmodule

// File: rtl/spi_slave_mem_burst.sv
// SPI memory slave with burst read/write, wrapping address and error pulses.
// Optional build macro: SPI_SLAVE_PARITY_EN (even-parity bit after each word).
module spi_slave_mem_burst
   import spi_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic i_cs,
   input  logic i_mosi,
   output logic o_miso,
   output logic o_ready,
   output logic o_op_done,
   output logic o_err,
   output logic o_busy
);

   localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int unsigned CNT_W = $clog2(MAX_W + 2);

   state_t            state;
   op_t               op_q;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_inc_c;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en_c;
   logic              rd_en_c;
   logic              in_range_c;
   logic              rd_bit_c;
`ifdef SPI_SLAVE_PARITY_EN
   logic              par_bit;
   logic              par_ok_c;

   assign par_ok_c = ((^wdata) == par_bit);
   assign wr_en_c  = rst && (state == S_WCOMMIT) && in_range_c && par_ok_c;
`else
   assign wr_en_c  = rst && (state == S_WCOMMIT) && in_range_c;
`endif

   // Last in-range word wraps to 0; out-of-range addresses roll over naturally
   assign addr_inc_c = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
   assign rd_bit_c   = |(rd_data & (DATA_W'(1) << count));
   assign rd_en_c    = (state == S_RD_PREP);

   spi_slave_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wr_en      (wr_en_c),
      .wr_data    (wdata),
      .rd_en      (rd_en_c),
      .rd_data    (rd_data),
      .in_range_c (in_range_c)
   );

   // Frame sequencer; every output is the registered result of the current state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         op_q      <= OP_RD;
         addr      <= '0;
         count     <= '0;
         wdata     <= '0;
`ifdef SPI_SLAVE_PARITY_EN
         par_bit   <= 1'b0;
`endif
         o_miso    <= 1'b0;
         o_ready   <= 1'b0;
         o_op_done <= 1'b0;
         o_err     <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         o_miso    <= 1'b0;
         o_ready   <= 1'b0;
         o_op_done <= 1'b0;
         o_err     <= 1'b0;
         o_busy    <= 1'b1;
         if (i_cs && abortable(state)) begin
            state  <= S_IDLE;
            count  <= '0;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  count  <= '0;
                  o_busy <= ~i_cs;
                  if (!i_cs) begin
                     state <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (count == '0) begin
                     op_q  <= op_t'({1'b0, i_mosi});
                     count <= CNT_W'(1);
                  end else begin
                     op_q  <= op_t'({i_mosi, op_q[0]});
                     count <= '0;
                     state <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  addr <= ADDR_W'({i_mosi, addr} >> 1);
                  if (count == CNT_W'(ADDR_W - 1)) begin
                     count <= '0;
                     state <= is_write(op_q) ? S_WDATA : S_RD_PREP;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
               S_WDATA: begin
                  wdata <= DATA_W'({i_mosi, wdata} >> 1);
                  if (count == CNT_W'(DATA_W - 1)) begin
                     count <= '0;
`ifdef SPI_SLAVE_PARITY_EN
                     state <= S_WPAR;
`else
                     state <= S_WCOMMIT;
`endif
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
`ifdef SPI_SLAVE_PARITY_EN
               S_WPAR: begin
                  par_bit <= i_mosi;
                  state   <= S_WCOMMIT;
               end
`endif
               S_WCOMMIT: begin
                  o_op_done <= 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
                  o_err     <= ~in_range_c | ~par_ok_c;
`else
                  o_err     <= ~in_range_c;
`endif
                  if (is_burst(op_q) && !i_cs) begin
                     addr  <= addr_inc_c;
                     state <= S_WDATA;
                  end else begin
                     state  <= S_IDLE;
                     o_busy <= 1'b0;
                  end
               end
               S_RD_PREP: begin
                  o_ready <= 1'b1;
                  o_err   <= ~in_range_c;
                  count   <= '0;
                  state   <= S_RDATA;
               end
               S_RDATA: begin
                  o_miso <= rd_bit_c;
                  if (count == CNT_W'(DATA_W - 1)) begin
                     count <= '0;
`ifdef SPI_SLAVE_PARITY_EN
                     state <= S_RPAR;
`else
                     state <= S_RDONE;
`endif
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
`ifdef SPI_SLAVE_PARITY_EN
               S_RPAR: begin
                  o_miso <= ^rd_data;
                  state  <= S_RDONE;
               end
`endif
               S_RDONE: begin
                  o_op_done <= 1'b1;
                  if (is_burst(op_q) && !i_cs) begin
                     addr  <= addr_inc_c;
                     state <= S_RD_PREP;
                  end else begin
                     state  <= S_IDLE;
                     o_busy <= 1'b0;
                  end
               end
               default: begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_mem_burst.sv
// Self-checking bench: directed and random frames against a memory model.
module tb_spi_slave_mem_burst;

   logic clk;
   logic rst;
   logic cs_a, mosi_a, miso_a, ready_a, done_a, err_a, busy_a;
   logic cs_b, mosi_b, miso_b, ready_b, done_b, err_b, busy_b;

   logic s_miso, s_ready, s_done, s_err, s_busy;
   int   n_assert;
   int   n_fail;
   int   n_done;
   int   n_err;

   logic [7:0]  mem_m   [2][32];
   int unsigned depth_m [2];
   logic [7:0]  wbuf    [32];
   logic [7:0]  last_rd;

   spi_slave_mem_burst u_a (
      .clk(clk), .rst(rst), .i_cs(cs_a), .i_mosi(mosi_a), .o_miso(miso_a),
      .o_ready(ready_a), .o_op_done(done_a), .o_err(err_a), .o_busy(busy_a));

   spi_slave_mem_burst #(.DATA_W(8), .ADDR_W(5), .DEPTH(20)) u_b (
      .clk(clk), .rst(rst), .i_cs(cs_b), .i_mosi(mosi_b), .o_miso(miso_b),
      .o_ready(ready_b), .o_op_done(done_b), .o_err(err_b), .o_busy(busy_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive selected instance, then sample its outputs after the edge
   task automatic cyc(input int d, input logic cs, input logic mosi);
      if (d == 0) begin
         cs_a = cs;   mosi_a = mosi; cs_b = 1'b1; mosi_b = 1'b0;
      end else begin
         cs_b = cs;   mosi_b = mosi; cs_a = 1'b1; mosi_a = 1'b0;
      end
      @(posedge clk);
      #1;
      if (d == 0) begin
         s_miso = miso_a; s_ready = ready_a; s_done = done_a; s_err = err_a; s_busy = busy_a;
      end else begin
         s_miso = miso_b; s_ready = ready_b; s_done = done_b; s_err = err_b; s_busy = busy_b;
      end
      n_done += int'(s_done);
      n_err  += int'(s_err);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_miso"},  s_miso,  0);
      chk({tag, "_ready"}, s_ready, 0);
      chk({tag, "_done"},  s_done,  0);
      chk({tag, "_err"},   s_err,   0);
      chk({tag, "_busy"},  s_busy,  0);
   endtask

   function automatic int unsigned nxt(input int unsigned a, input int unsigned dep);
      return (a == dep - 1) ? 0 : (a + 1) % 32;
   endfunction

   // Select, opcode (LSB first), address (LSB first)
   task automatic start(input int d, input logic [1:0] op, input int unsigned a0);
      logic [4:0] av;
      av = 5'(a0);
      cyc(d, 1'b0, 1'b0);
      chk("start_busy", s_busy, 1);
      cyc(d, 1'b0, op[0]);
      cyc(d, 1'b0, op[1]);
      for (int b = 0; b < 5; b++) begin
         cyc(d, 1'b0, av[0]);
         av = av >> 1;
      end
   endtask

   task automatic write_frame(input int d, input bit burst, input int unsigned a0,
                              input int n, input bit bad);
      int unsigned a;
      int          d0, e0, exp_e;
      logic [7:0]  w, sh;
      bit          inr;
      a = a0; d0 = n_done; e0 = n_err; exp_e = 0;
      start(d, burst ? 2'b11 : 2'b01, a0);
      for (int i = 0; i < n; i++) begin
         w   = wbuf[i];
         sh  = w;
         inr = (a < depth_m[d]);
         for (int b = 0; b < 8; b++) begin
            cyc(d, 1'b0, sh[0]);
            sh = sh >> 1;
         end
`ifdef SPI_SLAVE_PARITY_EN
         cyc(d, 1'b0, (^w) ^ bad);
`endif
         cyc(d, (i == n - 1), 1'b0);
         chk("wr_done", s_done, 1);
`ifdef SPI_SLAVE_PARITY_EN
         chk("wr_err", s_err, (!inr || bad));
         if (!inr || bad) exp_e++;
         else mem_m[d][a] = w;
`else
         chk("wr_err", s_err, !inr);
         if (!inr) exp_e++;
         else mem_m[d][a] = w;
`endif
         a = nxt(a, depth_m[d]);
      end
      chk("wr_done_cnt", n_done - d0, n);
      chk("wr_err_cnt", n_err - e0, exp_e);
      cyc(d, 1'b1, 1'b0);
      chk("wr_idle_busy", s_busy, 0);
   endtask

   task automatic read_frame(input int d, input bit burst, input int unsigned a0, input int n);
      int unsigned a;
      int          d0, e0, exp_e;
      logic [7:0]  exp, got;
      bit          inr;
      a = a0; d0 = n_done; e0 = n_err; exp_e = 0;
      start(d, burst ? 2'b10 : 2'b00, a0);
      for (int i = 0; i < n; i++) begin
         inr = (a < depth_m[d]);
         exp = inr ? mem_m[d][a] : 8'h00;
         if (!inr) exp_e++;
         cyc(d, 1'b0, 1'b0);
         chk("rd_ready", s_ready, 1);
         chk("rd_err", s_err, !inr);
         got = 8'h00;
         for (int b = 0; b < 8; b++) begin
            cyc(d, 1'b0, 1'b0);
            got = {s_miso, got[7:1]};
         end
`ifdef SPI_SLAVE_PARITY_EN
         cyc(d, 1'b0, 1'b0);
         chk("rd_parity", s_miso, ^exp);
`endif
         cyc(d, (i == n - 1), 1'b0);
         chk("rd_done", s_done, 1);
         chk("rd_miso_idle", s_miso, 0);
         chk("rd_data", got, exp);
         last_rd = got;
         a = nxt(a, depth_m[d]);
      end
      chk("rd_done_cnt", n_done - d0, n);
      chk("rd_err_cnt", n_err - e0, exp_e);
      cyc(d, 1'b1, 1'b0);
      chk("rd_idle_busy", s_busy, 0);
   endtask

   initial begin
      int          d, n;
      int unsigned a;
      logic [1:0]  op;
      bit          bad;
      n_assert = 0; n_fail = 0; n_done = 0; n_err = 0;
      depth_m[0] = 32; depth_m[1] = 20;
      last_rd = 8'h00;
      for (int i = 0; i < 32; i++) begin
         mem_m[0][i] = 8'h00;
         mem_m[1][i] = 8'h00;
      end
      rst = 1'b0; cs_a = 1'b1; cs_b = 1'b1; mosi_a = 1'b0; mosi_b = 1'b0;

      // Reset state of both instances
      cyc(0, 1'b1, 1'b0);
      cyc(0, 1'b1, 1'b0);
      chk_quiet("reset_a");
      cyc(1, 1'b1, 1'b0);
      chk_quiet("reset_b");
      rst = 1'b1;
      cyc(0, 1'b1, 1'b0);
      chk_quiet("idle_a");

      // Preload every word with one long wrapping burst per instance
      for (int i = 0; i < 32; i++) wbuf[i] = 8'($urandom);
      write_frame(0, 1'b1, 0, 32, 1'b0);
      write_frame(1, 1'b1, 0, 20, 1'b0);
      read_frame(0, 1'b1, 28, 6);

      // Single write/read of 0xA5 at address 3
      wbuf[0] = 8'hA5;
      write_frame(0, 1'b0, 3, 1, 1'b0);
      read_frame(0, 1'b0, 3, 1);
      chk("tp_a5", last_rd, 8'hA5);

      // Burst write across the top of memory, read back
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      write_frame(0, 1'b1, 30, 3, 1'b0);
      read_frame(0, 1'b1, 30, 3);
      chk("tp_burst_wrap", last_rd, 8'h33);

      // Non-power-of-2 depth: out-of-range write/read and both wrap flavours
      wbuf[0] = 8'h7E;
      write_frame(1, 1'b0, 25, 1, 1'b0);
      read_frame(1, 1'b0, 25, 1);
      chk("tp_oor_read", last_rd, 8'h00);
      read_frame(1, 1'b1, 19, 2);
      read_frame(1, 1'b1, 30, 3);

      // Abort in write data: no write, no done, error pulse
      wbuf[0] = 8'h00;
      write_frame(0, 1'b0, 5, 1, 1'b0);
      start(0, 2'b01, 5);
      for (int b = 0; b < 4; b++) cyc(0, 1'b0, 1'b1);
      cyc(0, 1'b1, 1'b0);
      chk("abort_wd_err", s_err, 1);
      chk("abort_wd_done", s_done, 0);
      chk("abort_wd_busy", s_busy, 0);
      cyc(0, 1'b1, 1'b0);
      read_frame(0, 1'b0, 5, 1);
      chk("abort_wd_mem", last_rd, 8'h00);

      // Abort during command and during address
      cyc(0, 1'b0, 1'b0);
      cyc(0, 1'b1, 1'b0);
      chk("abort_cmd_err", s_err, 1);
      chk("abort_cmd_busy", s_busy, 0);
      cyc(0, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b1);
      cyc(0, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b1);
      cyc(0, 1'b0, 1'b1);
      cyc(0, 1'b1, 1'b0);
      chk("abort_addr_err", s_err, 1);
      chk("abort_addr_busy", s_busy, 0);
      cyc(0, 1'b1, 1'b0);

      // Abort during read data
      start(0, 2'b00, 3);
      cyc(0, 1'b0, 1'b0);
      for (int b = 0; b < 3; b++) cyc(0, 1'b0, 1'b0);
      cyc(0, 1'b1, 1'b0);
      chk("abort_rd_err", s_err, 1);
      chk("abort_rd_done", s_done, 0);
      chk("abort_rd_busy", s_busy, 0);
      cyc(0, 1'b1, 1'b0);

      // Reset while shifting read data
      start(0, 2'b00, 3);
      cyc(0, 1'b0, 1'b0);
      for (int b = 0; b < 3; b++) cyc(0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(0, 1'b0, 1'b0);
      chk_quiet("rst_rdata");
      rst = 1'b1;
      cyc(0, 1'b1, 1'b0);
      chk_quiet("rst_rdata_idle");
      read_frame(0, 1'b0, 3, 1);
      chk("rst_rdata_mem", last_rd, 8'hA5);

      // Reset in the commit cycle discards the word
      start(0, 2'b01, 7);
      for (int b = 0; b < 8; b++) cyc(0, 1'b0, 1'b1);
`ifdef SPI_SLAVE_PARITY_EN
      cyc(0, 1'b0, 1'b0);
`endif
      rst = 1'b0;
      cyc(0, 1'b1, 1'b0);
      chk_quiet("rst_commit");
      rst = 1'b1;
      cyc(0, 1'b1, 1'b0);
      read_frame(0, 1'b0, 7, 1);

`ifdef SPI_SLAVE_PARITY_EN
      // Bad parity skips the write; good parity stores it
      wbuf[0] = 8'h03;
      write_frame(0, 1'b0, 9, 1, 1'b1);
      read_frame(0, 1'b0, 9, 1);
      write_frame(0, 1'b0, 9, 1, 1'b0);
      read_frame(0, 1'b0, 9, 1);
      chk("par_store", last_rd, 8'h03);
`endif

      // Random mix of frames on both instances
      for (int k = 0; k < 40; k++) begin
         d  = int'($urandom_range(0, 1));
         op = 2'($urandom_range(0, 3));
         a  = $urandom_range(0, 31);
         n  = op[1] ? int'($urandom_range(1, 4)) : 1;
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
`ifdef SPI_SLAVE_PARITY_EN
         bad = ($urandom_range(0, 3) == 0);
`else
         bad = 1'b0;
`endif
         if (op[0]) write_frame(d, op[1], a, n, bad);
         else       read_frame(d, op[1], a, n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
